// File: rtl/l1_mem_req_sched_pkg.sv
// Shared sizing, request payload type and packed-field offset helper for the
// SM-to-L2 memory request scheduler.
package l1_arb_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned A_SRC_W   = 4;
  localparam int unsigned D_SRC_W   = IDX_W + A_SRC_W;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MASK_W    = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned CNT_W     = 3;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [OP_W-1:0]    param;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [MASK_W-1:0]  mask;
    logic [D_SRC_W-1:0] source;
  } mem_req_t;

  // Low bit of requester idx's slot in a bus packed at w bits per requester.
  function automatic int unsigned fld_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/l1_mem_req_sched_if.sv
// Bundle of the per-cache request bus, the shared L2 request channel and the
// response-credit return signals.
interface l1_mem_req_sched_if;
  import l1_arb_pkg::*;

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ*OP_W-1:0]    req_opcode_i;
  logic [NUM_REQ*OP_W-1:0]    req_param_i;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i;
  logic [NUM_REQ*DATA_W-1:0]  req_data_i;
  logic [NUM_REQ*MASK_W-1:0]  req_mask_i;
  logic [NUM_REQ*A_SRC_W-1:0] req_source_i;

  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [OP_W-1:0]            out_opcode_o;
  logic [OP_W-1:0]            out_param_o;
  logic [ADDR_W-1:0]          out_addr_o;
  logic [DATA_W-1:0]          out_data_o;
  logic [MASK_W-1:0]          out_mask_o;
  logic [D_SRC_W-1:0]         out_source_o;

  logic                       rsp_fire_i;
  logic [D_SRC_W-1:0]         rsp_source_i;
  logic [NUM_REQ-1:0]         outst_full_o;

  modport master (
    output req_valid_i, req_opcode_i, req_param_i, req_addr_i, req_data_i,
           req_mask_i, req_source_i, out_ready_i, rsp_fire_i, rsp_source_i,
    input  req_ready_o, out_valid_o, out_opcode_o, out_param_o, out_addr_o,
           out_data_o, out_mask_o, out_source_o, outst_full_o
  );

  modport slave (
    input  req_valid_i, req_opcode_i, req_param_i, req_addr_i, req_data_i,
           req_mask_i, req_source_i, out_ready_i, rsp_fire_i, rsp_source_i,
    output req_ready_o, out_valid_o, out_opcode_o, out_param_o, out_addr_o,
           out_data_o, out_mask_o, out_source_o, outst_full_o
  );

endinterface

// File: rtl/l1_mem_req_sched_rr_arb.sv
// Round-robin arbiter: grants the first eligible requester at or above the
// pointer (wrapping), and moves the pointer past the winner only on advance.
module rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   winner_c;
  logic               found_c;
  int unsigned        idx_c;

  // Rotating search starting at the pointer.
  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    found_c  = 1'b0;
    idx_c    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
      if (!found_c && elig_i[IDX_W'(idx_c)]) begin
        found_c                  = 1'b1;
        grant_c[IDX_W'(idx_c)]   = 1'b1;
        winner_c                 = IDX_W'(idx_c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (winner_c == IDX_W'(NUM_REQ - 1)) ? '0 : winner_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign grant_o  = grant_c;
  assign winner_o = winner_c;
  assign any_o    = found_c;

endmodule

// File: rtl/l1_mem_req_sched.sv
// Shares the SM-to-L2 request channel among the L1 caches: round-robin grant,
// one-entry registered output stage and per-requester in-flight credit limit.
module l1_mem_req_sched
  import l1_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  l1_mem_req_sched_if.slave bus
);

  logic [NUM_REQ-1:0]            elig_c, grant_c, inc_c, dec_c, zero_c;
  logic [IDX_W-1:0]              winner_c, rsp_idx_c;
  logic                          any_c, load_c, rsp_ok_c;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          out_valid_q, out_valid_d;
  mem_req_t                      out_q, out_d, win_c;

  // Credit check uses registered counts only, so a same-cycle response
  // cannot re-open a full requester until the next cycle.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig_c[i] = bus.req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .clk      (clk),
    .rst      (rst),
    .elig_i   (elig_c),
    .adv_i    (load_c),
    .grant_o  (grant_c),
    .winner_o (winner_c),
    .any_o    (any_c)
  );

  assign load_c          = !rst && any_c && (!out_valid_q || bus.out_ready_i);
  assign bus.req_ready_o = grant_c & {NUM_REQ{load_c}};

  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        win_c.opcode = bus.req_opcode_i[fld_lo(i, OP_W) +: OP_W];
        win_c.param  = bus.req_param_i[fld_lo(i, OP_W) +: OP_W];
        win_c.addr   = bus.req_addr_i[fld_lo(i, ADDR_W) +: ADDR_W];
        win_c.data   = bus.req_data_i[fld_lo(i, DATA_W) +: DATA_W];
        win_c.mask   = bus.req_mask_i[fld_lo(i, MASK_W) +: MASK_W];
        win_c.source = {IDX_W'(i), bus.req_source_i[fld_lo(i, A_SRC_W) +: A_SRC_W]};
      end
    end
  end

  // Output stage: fields change only on load and hold through drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (load_c) begin
      out_valid_d = 1'b1;
      out_d       = win_c;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  assign rsp_idx_c = bus.rsp_source_i[D_SRC_W-1 -: IDX_W];
  assign rsp_ok_c  = 32'(rsp_idx_c) < NUM_REQ;

  // Same-cycle issue and response cancel; a zero counter never underflows.
  always_comb begin
    cnt_d  = cnt_q;
    inc_c  = '0;
    dec_c  = '0;
    zero_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc_c[i]  = load_c && grant_c[i];
      dec_c[i]  = bus.rsp_fire_i && rsp_ok_c && (32'(rsp_idx_c) == i);
      zero_c[i] = (cnt_q[i] == '0);
      if (inc_c[i] && !dec_c[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_c[i] && !inc_c[i] && !zero_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    bus.outst_full_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.outst_full_o[i] = (cnt_q[i] == CNT_W'(MAX_OUTST));
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_opcode_o = out_q.opcode;
  assign bus.out_param_o  = out_q.param;
  assign bus.out_addr_o   = out_q.addr;
  assign bus.out_data_o   = out_q.data;
  assign bus.out_mask_o   = out_q.mask;
  assign bus.out_source_o = out_q.source;

`ifndef SYNTHESIS
  // Responses must name a real requester with at least one request in flight.
  always_ff @(posedge clk) begin
    if (!rst && bus.rsp_fire_i) begin
      a_rsp_idx_range: assert (rsp_ok_c);
      a_rsp_underflow: assert ((dec_c & zero_c & ~inc_c) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_l1_mem_req_sched.sv
// Bench for l1_mem_req_sched: directed scenarios plus random traffic checked
// against a transaction-level model of the scheduler.
module tb_l1_mem_req_sched;
  import l1_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_mem_req_sched_if bus();

  l1_mem_req_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Per-requester pending request presented on the bus.
  logic [OP_W-1:0]    c_op   [NUM_REQ];
  logic [OP_W-1:0]    c_par  [NUM_REQ];
  logic [ADDR_W-1:0]  c_addr [NUM_REQ];
  logic [DATA_W-1:0]  c_data [NUM_REQ];
  logic [MASK_W-1:0]  c_mask [NUM_REQ];
  logic [A_SRC_W-1:0] c_src  [NUM_REQ];

  // Reference model state.
  int                 m_ptr;
  int                 m_cnt [NUM_REQ];
  bit                 m_ov;
  logic [OP_W-1:0]    e_op, e_par;
  logic [ADDR_W-1:0]  e_addr;
  logic [DATA_W-1:0]  e_data;
  logic [MASK_W-1:0]  e_mask;
  logic [D_SRC_W-1:0] e_src;
  logic [D_SRC_W-1:0] infl [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic new_req(input int i);
    c_op[i]   = OP_W'($urandom);
    c_par[i]  = OP_W'($urandom);
    c_addr[i] = ADDR_W'($urandom);
    c_data[i] = DATA_W'({$urandom, $urandom});
    c_mask[i] = MASK_W'($urandom);
    c_src[i]  = A_SRC_W'($urandom);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    e_op = '0; e_par = '0; e_addr = '0; e_data = '0; e_mask = '0; e_src = '0;
    infl.delete();
  endtask

  task automatic take_rsp(input int idx, output logic [D_SRC_W-1:0] s);
    bit found = 1'b0;
    s = '0;
    for (int j = 0; j < infl.size(); j++) begin
      if (!found && int'(infl[j] >> A_SRC_W) == idx) begin
        s = infl[j];
        infl.delete(j);
        found = 1'b1;
      end
    end
  endtask

  // One clock of stimulus; checks combinational outputs before the edge and
  // registered outputs just after it.
  task automatic cycle(input logic [NUM_REQ-1:0] v, input bit rdy, input bit fire,
                       input logic [D_SRC_W-1:0] rsrc);
    int w;
    bit ld;
    logic [NUM_REQ-1:0] exp_rdy, exp_full;
    bus.req_valid_i  = v;
    bus.out_ready_i  = rdy;
    bus.rsp_fire_i   = fire;
    bus.rsp_source_i = rsrc;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_opcode_i[i*OP_W +: OP_W]        = c_op[i];
      bus.req_param_i[i*OP_W +: OP_W]         = c_par[i];
      bus.req_addr_i[i*ADDR_W +: ADDR_W]      = c_addr[i];
      bus.req_data_i[i*DATA_W +: DATA_W]      = c_data[i];
      bus.req_mask_i[i*MASK_W +: MASK_W]      = c_mask[i];
      bus.req_source_i[i*A_SRC_W +: A_SRC_W]  = c_src[i];
    end
    #2;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_REQ;
      if (w < 0 && v[idx] && m_cnt[idx] < MAX_OUTST) w = idx;
    end
    ld = !rst && (w >= 0) && (!m_ov || rdy);
    exp_rdy = '0;
    if (ld) exp_rdy[w] = 1'b1;
    exp_full = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_full[i] = (m_cnt[i] == MAX_OUTST);
    chk("req_ready", bus.req_ready_o, exp_rdy);
    chk("outst_full", bus.outst_full_o, exp_full);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ld) begin
        e_op   = c_op[w];
        e_par  = c_par[w];
        e_addr = c_addr[w];
        e_data = c_data[w];
        e_mask = c_mask[w];
        e_src  = D_SRC_W'(w * (1 << A_SRC_W) + int'(c_src[w]));
        m_ov   = 1'b1;
        m_ptr  = (w + 1) % NUM_REQ;
        m_cnt[w]++;
        infl.push_back(e_src);
        new_req(w);
      end else if (m_ov && rdy) begin
        m_ov = 1'b0;
      end
      if (fire) m_cnt[int'(rsrc >> A_SRC_W)]--;
    end
    #1;
    chk("out_valid", bus.out_valid_o, m_ov);
    chk("out_source", bus.out_source_o, e_src);
    chk("out_addr", bus.out_addr_o, e_addr);
    chk("out_payload", {bus.out_opcode_o, bus.out_param_o, bus.out_data_o, bus.out_mask_o},
        {e_op, e_par, e_data, e_mask});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle('0, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    logic [D_SRC_W-1:0] s;
    bit f;
    for (int i = 0; i < NUM_REQ; i++) new_req(i);
    model_reset();
    bus.req_valid_i  = '0;
    bus.out_ready_i  = 1'b0;
    bus.rsp_fire_i   = 1'b0;
    bus.rsp_source_i = '0;
    bus.req_opcode_i = '0; bus.req_param_i = '0; bus.req_addr_i = '0;
    bus.req_data_i   = '0; bus.req_mask_i  = '0; bus.req_source_i = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fairness: both requesting, responses two cycles behind issue.
    for (int k = 0; k < 10; k++) begin
      f = (infl.size() >= 2);
      s = f ? infl.pop_front() : '0;
      cycle('1, 1'b1, f, s);
      chk("fair_idx", bus.out_source_o[D_SRC_W-1 -: IDX_W], k % 2);
    end

    // Backpressure: output frozen while downstream stalls.
    do_reset();
    c_addr[0] = 32'h1000;
    cycle(2'b01, 1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      cycle(2'b11, 1'b0, 1'b0, '0);
      chk("bp_addr", bus.out_addr_o, 32'h1000);
      chk("bp_ready", bus.req_ready_o, 0);
    end
    cycle(2'b11, 1'b1, 1'b0, '0);
    chk("bp_release_valid", bus.out_valid_o, 1);
    chk("bp_release_idx", bus.out_source_o[D_SRC_W-1 -: IDX_W], 1);
    cycle(2'b00, 1'b1, 1'b0, '0);
    chk("drain_valid", bus.out_valid_o, 0);

    // Credit limit and response arriving while full.
    do_reset();
    repeat (4) cycle(2'b01, 1'b1, 1'b0, '0);
    cycle(2'b11, 1'b1, 1'b0, '0);
    chk("credit_full", bus.outst_full_o[0], 1);
    chk("credit_other_granted", bus.out_source_o[D_SRC_W-1 -: IDX_W], 1);
    take_rsp(0, s);
    cycle(2'b01, 1'b1, 1'b1, s);
    chk("simul_no_grant", bus.out_valid_o, 0);
    chk("credit_clear", bus.outst_full_o[0], 0);
    cycle(2'b01, 1'b1, 1'b0, '0);
    chk("simul_grant_next_valid", bus.out_valid_o, 1);
    chk("simul_grant_next_idx", bus.out_source_o[D_SRC_W-1 -: IDX_W], 0);

    // Same-cycle issue and response on requester 1.
    do_reset();
    repeat (2) cycle(2'b10, 1'b1, 1'b0, '0);
    take_rsp(1, s);
    cycle(2'b10, 1'b1, 1'b1, s);
    cycle(2'b10, 1'b1, 1'b0, '0);
    chk("incdec_not_full_at3", bus.outst_full_o[1], 0);
    cycle(2'b10, 1'b1, 1'b0, '0);
    chk("incdec_full_at4", bus.outst_full_o[1], 1);

    // Reset in the middle of traffic with counts (3,2).
    do_reset();
    repeat (5) cycle(2'b11, 1'b1, 1'b0, '0);
    chk("midrst_pre_valid", bus.out_valid_o, 1);
    rst = 1'b1;
    cycle(2'b11, 1'b1, 1'b0, '0);
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid_o, 0);
    chk("midrst_full", bus.outst_full_o, 0);
    cycle(2'b11, 1'b1, 1'b0, '0);
    chk("midrst_first_idx", bus.out_source_o[D_SRC_W-1 -: IDX_W], 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      f = (infl.size() > 0) && ($urandom_range(0, 1) == 0);
      s = '0;
      if (f) begin
        int j;
        j = $urandom_range(0, infl.size() - 1);
        s = infl[j];
        infl.delete(j);
      end
      cycle(NUM_REQ'($urandom), $urandom_range(0, 3) != 0, f, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
